// File: rtl/orbit_pack_pkg.sv
// Shared types and helpers for the orbit frame packer.
package orbit_pack_pkg;

    // Per-word sequencer states; one word takes LOAD->WRITE->ACK->GAP.
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, ACK, GAP} packState_t;

    // Orbit word layout is {mark, data, zero pad}; data and pad widths are block parameters.
    localparam int MARK_W = 1;

    // Interleaved slot of word k of channel c inside one frame. The first half of a pack
    // lands on even slot groups and the second half on the odd ones, so the channels
    // interleave at single-word granularity across the whole frame.
    function automatic int slot_offset(input int nch, input int frame_log2,
                                       input int c, input int k);
        int h;
        h = (1 << frame_log2) / (2 * nch);
        return 2 * nch * (k % h) + nch * (k / h) + c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    // Highest-priority channel for the next search.
    logic [IW-1:0] ptr;

    // Walk from the farthest candidate down so the one nearest the pointer wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'((int'(ptr) + i) % N);
            end
        end
    end

    // Once a grant is taken, the channel after it gets top priority.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance && gnt_valid)
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/orbit_frame_packer.sv
// Drains per-channel show-ahead byte FIFOs into the orbit frame RAM, one whole pack at a time.
module orbit_frame_packer
    import orbit_pack_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int DW         = 8,
    parameter int USEDW_W    = 5,
    parameter int ADDR_W     = 11,
    parameter int FRAME_LOG2 = 5,
    parameter int PAD_W      = 3,
    parameter int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NCH*USEDW_W-1:0]    usedw,
    input  logic [NCH*DW-1:0]         fData,
    output logic [NCH-1:0]            rAck,
    output logic [ADDR_W-1:0]         wAddr,
    output logic [MARK_W+DW+PAD_W-1:0] orbWord,
    output logic                      WE,
    output logic                      pack_done,
    output logic [CH_W-1:0]           pack_ch
);

    localparam int WPC  = (1 << FRAME_LOG2) / NCH;
    localparam int K_W  = $clog2(WPC);
    localparam int PC_W = ADDR_W - FRAME_LOG2;
    localparam logic [USEDW_W:0] WPC_LVL = (USEDW_W + 1)'(WPC);

    packState_t           state, stateNext;
    logic [CH_W-1:0]      ch, gntIdx;
    logic [K_W-1:0]       k;
    logic [PC_W-1:0]      packCnt [NCH];
    logic [NCH-1:0]       req;
    logic                 gntValid, grantTake, lastWord;
    logic [DW-1:0]        headData;
    logic [FRAME_LOG2-1:0] slotOff;

    // A channel may only start once a full pack is sitting in its FIFO.
    for (genvar c = 0; c < NCH; c++) begin : g_req
        assign req[c] = {1'b0, usedw[c*USEDW_W +: USEDW_W]} >= WPC_LVL;
    end

    rr_arbiter #(.N(NCH), .IW(CH_W)) uArb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (grantTake),
        .gnt_idx   (gntIdx),
        .gnt_valid (gntValid)
    );

    assign headData = fData[ch*DW +: DW];
    assign slotOff  = FRAME_LOG2'(slot_offset(NCH, FRAME_LOG2, int'(ch), int'(k)));
    assign lastWord = (k == K_W'(WPC - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state: grants are only taken in IDLE, so usedw is re-judged between packs only.
    always_comb begin
        stateNext = state;
        grantTake = 1'b0;
        case (state)
            IDLE: if (en && gntValid) begin
                stateNext = LOAD;
                grantTake = 1'b1;
            end
            LOAD:    stateNext = WRITE;
            WRITE:   stateNext = ACK;
            ACK:     stateNext = GAP;
            GAP:     stateNext = lastWord ? IDLE : LOAD;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath: registered RAM write, pop strobe, word index and per-channel frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch        <= '0;
            k         <= '0;
            wAddr     <= '0;
            orbWord   <= '0;
            WE        <= 1'b0;
            rAck      <= '0;
            pack_done <= 1'b0;
            pack_ch   <= '0;
            for (int i = 0; i < NCH; i++) packCnt[i] <= '0;
        end else begin
            WE        <= 1'b0;
            rAck      <= '0;
            pack_done <= 1'b0;
            case (state)
                IDLE: if (grantTake) begin
                    ch <= gntIdx;
                    k  <= '0;
                end
                LOAD: begin
                    wAddr   <= {packCnt[ch], slotOff};
                    orbWord <= {(k == '0), headData, {PAD_W{1'b0}}};
                    WE      <= 1'b1;
                end
                WRITE: rAck <= NCH'(1) << ch;
                GAP: begin
                    k <= k + 1'b1;
                    if (lastWord) begin
                        packCnt[ch] <= packCnt[ch] + 1'b1;
                        pack_done   <= 1'b1;
                        pack_ch     <= ch;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
